// File: rtl/tcc32_pwm_seq.sv
// APB master sequencer: programs a TCC32 timer for PWM, then optionally counts timer timeouts.
// Define TCC32_SEQ_TIMEOUT_EN to add a 256-cycle PREADY watchdog that drives err.
module tcc32_pwm_seq #(
  parameter logic [31:0] PERIOD_ADDR = 32'h0000_0000,
  parameter logic [31:0] CMP_ADDR    = 32'h0000_0004,
  parameter logic [31:0] CTRL_ADDR   = 32'h0000_0008,
  parameter logic [31:0] RIS_ADDR    = 32'h0000_000C,
  parameter logic [31:0] ICR_ADDR    = 32'h0000_0010
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_period,
  input  logic [31:0] cfg_cmp,
  input  logic [31:0] cfg_ctrl,
  input  logic [15:0] cfg_n_to,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        err,
  output logic [15:0] to_count
);

  typedef enum logic [3:0] {
    StIdle,
    StWrCtrl0,
    StWrPeriod,
    StWrIcr,
    StWrCmp,
    StWrCtrl,
    StRdRis,
    StWrClr,
    StWrStop,
    StFin
  } state_e;

  // Every transfer state walks gap -> setup -> access; the gap keeps PSEL low between transfers.
  typedef enum logic [1:0] {
    PhGap,
    PhSetup,
    PhAccess
  } phase_e;

  state_e state_q, state_d, nxt_state;
  phase_e phase_q, phase_d;

  logic [31:0] period_q, cmp_q, ctrl_q;
  logic [15:0] n_to_q;
  logic [15:0] to_count_q, to_count_inc;
  logic        abort_q, aborted_q;

  logic accept, in_xfer, in_access, xfer_done, timeout, abort_pend, abort_take;
  logic unused_prdata;

  assign unused_prdata = ^PRDATA[31:1];

  assign accept       = (state_q == StIdle) && start;
  assign in_xfer      = (state_q != StIdle) && (state_q != StFin);
  assign in_access    = in_xfer && (phase_q == PhAccess);
  assign xfer_done    = in_access && PREADY;
  assign abort_pend   = abort_q | abort;
  assign to_count_inc = (to_count_q == 16'hFFFF) ? to_count_q : to_count_q + 16'd1;

`ifdef TCC32_SEQ_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       err_q;

  // wait_q == 255 marks the 256th stalled ACCESS cycle.
  assign timeout = in_access && !PREADY && (wait_q == 8'hFF);
  assign err     = err_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (in_access && !PREADY) begin
        wait_q <= wait_q + 8'd1;
      end else begin
        wait_q <= '0;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= StIdle;
      phase_q <= PhGap;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Successor of each transfer state when it completes normally
  always_comb begin
    nxt_state = StIdle;
    case (state_q)
      StWrCtrl0:  nxt_state = StWrPeriod;
      StWrPeriod: nxt_state = StWrIcr;
      StWrIcr:    nxt_state = StWrCmp;
      StWrCmp:    nxt_state = StWrCtrl;
      StWrCtrl:   nxt_state = (n_to_q == 16'd0) ? StFin : StRdRis;
      StRdRis:    nxt_state = PRDATA[0] ? StWrClr : StRdRis;
      StWrClr:    nxt_state = (to_count_inc == n_to_q) ? StWrStop : StRdRis;
      StWrStop:   nxt_state = StFin;
      default:    nxt_state = StIdle;
    endcase
  end

  // Next-state logic; abort and watchdog only redirect at the end of an ACCESS phase
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    abort_take = 1'b0;
    if (state_q == StIdle) begin
      if (start) begin
        state_d = StWrCtrl0;
        phase_d = PhSetup;
      end
    end else if (state_q == StFin) begin
      state_d = StIdle;
      phase_d = PhGap;
    end else begin
      case (phase_q)
        PhGap:   phase_d = PhSetup;
        PhSetup: phase_d = PhAccess;
        PhAccess: begin
          if (timeout) begin
            state_d = StFin;
            phase_d = PhGap;
          end else if (PREADY) begin
            phase_d = PhGap;
            if (abort_pend && (state_q != StWrStop)) begin
              state_d    = StWrStop;
              abort_take = 1'b1;
            end else begin
              state_d = nxt_state;
            end
          end
        end
        default: phase_d = PhGap;
      endcase
    end
  end

  // Latched configuration, timeout counter and abort bookkeeping
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      period_q   <= '0;
      cmp_q      <= '0;
      ctrl_q     <= '0;
      n_to_q     <= '0;
      to_count_q <= '0;
      aborted_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      if (accept) begin
        period_q   <= cfg_period;
        cmp_q      <= cfg_cmp;
        ctrl_q     <= cfg_ctrl;
        n_to_q     <= cfg_n_to;
        to_count_q <= '0;
        aborted_q  <= 1'b0;
      end else begin
        if (xfer_done && (state_q == StWrClr)) begin
          to_count_q <= to_count_inc;
        end
        if (abort_take) begin
          aborted_q <= 1'b1;
        end
      end
      // Requests seen in IDLE (including one coinciding with start) are dropped
      if ((state_q == StIdle) || (state_q == StFin)) begin
        abort_q <= 1'b0;
      end else if (abort) begin
        abort_q <= 1'b1;
      end
    end
  end

  // Outputs decode from state only, so reset drops PSEL/PENABLE asynchronously
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    if (in_xfer && (phase_q != PhGap)) begin
      PSEL    = 1'b1;
      PENABLE = (phase_q == PhAccess);
      PWRITE  = 1'b1;
      case (state_q)
        StWrCtrl0:  PADDR = CTRL_ADDR;
        StWrPeriod: begin
          PADDR  = PERIOD_ADDR;
          PWDATA = period_q;
        end
        StWrIcr: begin
          PADDR  = ICR_ADDR;
          PWDATA = 32'h0000_0007;
        end
        StWrCmp: begin
          PADDR  = CMP_ADDR;
          PWDATA = cmp_q;
        end
        StWrCtrl: begin
          PADDR  = CTRL_ADDR;
          PWDATA = ctrl_q;
        end
        StRdRis: begin
          PADDR  = RIS_ADDR;
          PWRITE = 1'b0;
        end
        StWrClr: begin
          PADDR  = ICR_ADDR;
          PWDATA = 32'h0000_0001;
        end
        StWrStop:   PADDR = CTRL_ADDR;
        default:    PADDR = '0;
      endcase
    end
  end

  assign busy     = in_xfer;
  assign done     = (state_q == StFin);
  assign aborted  = aborted_q;
  assign to_count = to_count_q;

endmodule

// File: tb/tb_tcc32_pwm_seq.sv
// Bench for tcc32_pwm_seq: APB slave model with stalls and a RIS timer, plus a write scoreboard.
// All timing runs in one process; cycle() advances to the next falling edge and monitors the bus.
`timescale 1ns/1ps
module tb_tcc32_pwm_seq;

  localparam logic [31:0] PERIOD_A = 32'h0000_0000;
  localparam logic [31:0] CMP_A    = 32'h0000_0004;
  localparam logic [31:0] CTRL_A   = 32'h0000_0008;
  localparam logic [31:0] RIS_A    = 32'h0000_000C;
  localparam logic [31:0] ICR_A    = 32'h0000_0010;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_cmp = '0;
  logic [31:0] cfg_ctrl = '0;
  logic [15:0] cfg_n_to = '0;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        PREADY = 1'b1;
  logic        busy, done, aborted, err;
  logic [15:0] to_count;

  xfer_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int          acc_len = 0, acc_max = 0, rd_count = 0;
  int          stall_n = 0, ris_cd = 0;
  logic [31:0] stall_addr = '0;
  logic [31:0] su_addr = '0, su_data = '0;
  logic        su_wr = 1'b0, prev_psel = 1'b0, ris = 1'b0;

  assign PRDATA = {31'd0, ris};

  always #5 PCLK = ~PCLK;

  tcc32_pwm_seq dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .start      (start),
    .abort      (abort),
    .cfg_period (cfg_period),
    .cfg_cmp    (cfg_cmp),
    .cfg_ctrl   (cfg_ctrl),
    .cfg_n_to   (cfg_n_to),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err        (err),
    .to_count   (to_count)
  );

  initial begin
    #400000;
    $display("FAIL watchdog got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Falling-edge step: slave responder, RIS timer, protocol checks and scoreboard pops
  task automatic cycle();
    xfer_t e;
    @(negedge PCLK);
    cyc++;
    if (ris_cd > 0) begin
      ris_cd--;
      if (ris_cd == 0) ris = 1'b1;
    end
    if (!(PSEL && PENABLE)) PREADY = 1'b1;
    if (PSEL && !PENABLE) begin
      checks++;
      if (prev_psel !== 1'b0) begin
        errors++;
        $display("FAIL apb_gap got prev PSEL %0b expected 0", prev_psel);
      end
      acc_len = 0;
      su_addr = PADDR;
      su_data = PWDATA;
      su_wr   = PWRITE;
    end
    if (PSEL && PENABLE) begin
      acc_len++;
      if (acc_len > acc_max) acc_max = acc_len;
      PREADY = !(PWRITE && (PADDR == stall_addr) && (acc_len <= stall_n));
      checks++;
      if ({PADDR, PWDATA, PWRITE} !== {su_addr, su_data, su_wr}) begin
        errors++;
        $display("FAIL apb_stable got %h/%h/%b expected %h/%h/%b",
                 PADDR, PWDATA, PWRITE, su_addr, su_data, su_wr);
      end
      if (PREADY) begin
        if (PWRITE) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write got addr %h data %h expected none", PADDR, PWDATA);
          end else begin
            e = exp_q.pop_front();
            if ({PADDR, PWDATA} !== {e.addr, e.data}) begin
              errors++;
              $display("FAIL write_order got addr %h data %h expected addr %h data %h",
                       PADDR, PWDATA, e.addr, e.data);
            end
          end
          last_wr_cyc = cyc;
          if (PADDR == ICR_A) begin
            ris    = 1'b0;
            ris_cd = 20;
          end
        end else begin
          rd_count++;
        end
      end
    end
    checks++;
    if (done === 1'b1 && busy === 1'b1) begin
      errors++;
      $display("FAIL done_busy_overlap got done=1 busy=1 expected not both");
    end
    if (done === 1'b1) done_cyc = cyc;
    prev_psel = PSEL;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    xfer_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input logic [31:0] p, input logic [31:0] c, input logic [31:0] t);
    push_wr(CTRL_A, 32'h0);
    push_wr(PERIOD_A, p);
    push_wr(ICR_A, 32'h7);
    push_wr(CMP_A, c);
    push_wr(CTRL_A, t);
  endtask

  // One-cycle start pulse; returns at the falling edge after acceptance
  task automatic launch(input logic [31:0] p, input logic [31:0] c, input logic [31:0] t,
                        input logic [15:0] n, input logic ab);
    cycle();
    cfg_period = p;
    cfg_cmp    = c;
    cfg_ctrl   = t;
    cfg_n_to   = n;
    start      = 1'b1;
    abort      = ab;
    acc_max    = 0;
    rd_count   = 0;
    cycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    cycle();
    cycle();
    checks++;
    if ({PSEL, PENABLE, PWRITE, busy, done, aborted, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 0000000",
               {PSEL, PENABLE, PWRITE, busy, done, aborted, err});
    end
    checks++;
    if ({PADDR, PWDATA, to_count} !== 80'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h expected 0 0 0", PADDR, PWDATA, to_count);
    end
    PRESET = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy %b PSEL %b expected 0 0", busy, PSEL);
    end
  endtask

  task automatic test_basic();
    bit ok;
    push_init(32'd1024, 32'd512, 32'h7);
    launch(32'd1024, 32'd512, 32'h7, 16'd0, 1'b0);
    checks++;
    if (busy !== 1'b1 || PSEL !== 1'b1 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL start_setup got busy %b PSEL %b PENABLE %b expected 1 1 0",
               busy, PSEL, PENABLE);
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done got no done expected done within 200 cycles");
    end
    checks++;
    if (done_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_latency got %0d expected %0d", done_cyc, last_wr_cyc + 1);
    end
    checks++;
    if (acc_max !== 1) begin
      errors++;
      $display("FAIL basic_access_len got %0d expected 1", acc_max);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_writes_left got %0d expected 0", exp_q.size());
    end
    checks++;
    if ({aborted, err, to_count} !== 18'h0) begin
      errors++;
      $display("FAIL basic_status got ab %b err %b cnt %0d expected 0 0 0", aborted, err, to_count);
    end
    cycle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b expected 0", done);
    end
  endtask

  task automatic test_stall();
    bit ok;
    stall_addr = PERIOD_A;
    stall_n    = 5;
    push_init(32'd300, 32'd100, 32'h3);
    launch(32'd300, 32'd100, 32'h3, 16'd0, 1'b0);
    wait_done(200, ok);
    stall_n = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_done got no done expected done within 200 cycles");
    end
    checks++;
    if (acc_max !== 6) begin
      errors++;
      $display("FAIL stall_access_len got %0d expected 6", acc_max);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_writes_left got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_init(32'hA5A5_0001, 32'h0000_1111, 32'h5);
    launch(32'hA5A5_0001, 32'h0000_1111, 32'h5, 16'd0, 1'b0);
    cycle();
    cycle();
    // start while busy must not relatch configuration
    cfg_period = 32'hDEAD_0002;
    cfg_cmp    = 32'h0000_2222;
    cfg_ctrl   = 32'h6;
    start      = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL busy_start got done %b left %0d expected 1 0", ok, exp_q.size());
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    push_init(32'hDEAD_0002, 32'h0000_2222, 32'h6);
    launch(32'hDEAD_0002, 32'h0000_2222, 32'h6, 16'd0, 1'b1);
    wait_done(200, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_run got done %b left %0d expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start got aborted %b expected 0", aborted);
    end
    checks++;
    if (done_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL b2b_done_latency got %0d expected %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit found;
    push_init(32'd50, 32'd25, 32'h7);
    push_wr(CTRL_A, 32'h0);
    launch(32'd50, 32'd25, 32'h7, 16'd10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (PSEL && PENABLE && !PWRITE) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_read_seen got none expected RIS read access");
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_run got done %b left %0d expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (aborted !== 1'b1 || to_count >= 16'd10 || $isunknown(to_count)) begin
      errors++;
      $display("FAIL abort_status got aborted %b cnt %0d expected 1 <10", aborted, to_count);
    end
    checks++;
    if (rd_count !== 1) begin
      errors++;
      $display("FAIL abort_reads got %0d expected 1", rd_count);
    end
    cycle();
    cycle();
    checks++;
    if (aborted !== 1'b1) begin
      errors++;
      $display("FAIL aborted_hold got %b expected 1", aborted);
    end
  endtask

  task automatic test_timeouts();
    bit ok;
    push_init(32'd20, 32'd10, 32'h7);
    for (int i = 0; i < 3; i++) push_wr(ICR_A, 32'h1);
    push_wr(CTRL_A, 32'h0);
    launch(32'd20, 32'd10, 32'h7, 16'd3, 1'b0);
    checks++;
    if (aborted !== 1'b0) begin
      errors++;
      $display("FAIL aborted_clear got %b expected 0", aborted);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeouts_run got done %b left %0d expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (to_count !== 16'd3) begin
      errors++;
      $display("FAIL timeouts_count got %0d expected 3", to_count);
    end
    checks++;
    if (rd_count <= 3) begin
      errors++;
      $display("FAIL timeouts_polls got %0d expected more than 3", rd_count);
    end
    checks++;
    if (done_cyc !== last_wr_cyc + 1) begin
      errors++;
      $display("FAIL timeouts_done_latency got %0d expected %0d", done_cyc, last_wr_cyc + 1);
    end
  endtask

`ifdef TCC32_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    stall_addr = ICR_A;
    stall_n    = 100000;
    push_wr(CTRL_A, 32'h0);
    push_wr(PERIOD_A, 32'd77);
    launch(32'd77, 32'd33, 32'h7, 16'd0, 1'b0);
    wait_done(600, ok);
    stall_n = 0;
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_run got done %b left %0d expected 1 0", ok, exp_q.size());
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %b expected 1", err);
    end
    checks++;
    if (acc_len !== 256) begin
      errors++;
      $display("FAIL timeout_access_len got %0d expected 256", acc_len);
    end
    push_init(32'd77, 32'd33, 32'h7);
    launch(32'd77, 32'd33, 32'h7, 16'd0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b expected 0", err);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL timeout_recover got done %b left %0d expected 1 0", ok, exp_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bit found;
    stall_addr = CMP_A;
    stall_n    = 100000;
    push_wr(CTRL_A, 32'h0);
    push_wr(PERIOD_A, 32'd900);
    push_wr(ICR_A, 32'h7);
    launch(32'd900, 32'd450, 32'h7, 16'd4, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (PSEL && PENABLE && PADDR == CMP_A) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_seen got none expected CMP access");
    end
    #1 PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0 || {PADDR, PWDATA} !== 64'h0) begin
      errors++;
      $display("FAIL reset_async got %b %h %h expected 0000 0 0",
               {PSEL, PENABLE, PWRITE, busy}, PADDR, PWDATA);
    end
    stall_n = 0;
    cycle();
    cycle();
    checks++;
    if ({done, aborted, err, to_count} !== 19'h0 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_state got %b %0d left %0d expected 000 0 left 0",
               {done, aborted, err}, to_count, exp_q.size());
    end
    PRESET = 1'b0;
    cycle();
    cycle();
    checks++;
    if (PSEL !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume got PSEL %b busy %b expected 0 0", PSEL, busy);
    end
    push_init(32'd64, 32'd16, 32'h7);
    launch(32'd64, 32'd16, 32'h7, 16'd0, 1'b0);
    wait_done(200, ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_restart got done %b left %0d expected 1 0", ok, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_abort();
    test_timeouts();
`ifdef TCC32_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcc32_pwm_seq.md
TCC32_PWM_SEQ -- requirements
Module: tcc32_pwm_seq

Interface
REQ-001 SHALL have parameter PERIOD_ADDR, default 32'h0000_0000, TCC32 period register address.
REQ-002 SHALL have parameter CMP_ADDR, default 32'h0000_0004, PWM compare register address.
REQ-003 SHALL have parameter CTRL_ADDR, default 32'h0000_0008, control register address.
REQ-004 SHALL have parameter RIS_ADDR, default 32'h0000_000C, raw interrupt status register address.
REQ-005 SHALL have parameter ICR_ADDR, default 32'h0000_0010, interrupt clear register address.
REQ-006 SHALL have ports: PCLK in 1 clock; PRESET in 1 reset, asynchronous active-high (one clock; reset is asynchronous and active-high).
REQ-007 SHALL have ports: start in 1 begin sequence; abort in 1 request early stop; cfg_period in 32; cfg_cmp in 32; cfg_ctrl in 32 enable word; cfg_n_to in 16 timeouts to wait (0 = free-run).
REQ-008 SHALL have APB master ports: PADDR out 32; PSEL out 1; PENABLE out 1; PWRITE out 1; PWDATA out 32; PRDATA in 32; PREADY in 1.
REQ-009 SHALL have status ports: busy out 1; done out 1 (one-cycle pulse); aborted out 1; err out 1; to_count out 16.

Function
REQ-010 SHALL latch all cfg_* on the cycle start=1 is seen in IDLE; start while busy is ignored.
REQ-011 SHALL perform writes in order: CTRL=0, PERIOD=cfg_period, ICR=32'h7, CMP=cfg_cmp, CTRL=cfg_ctrl.
REQ-012 Each APB transfer SHALL be: SETUP one cycle (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1) held until PREADY=1; PADDR/PWRITE/PWDATA stable across both phases.
REQ-013 Between transfers PSEL and PENABLE SHALL be 0 for at least one cycle.
REQ-014 If cfg_n_to=0, done SHALL pulse the cycle after the CTRL=cfg_ctrl transfer completes, timer left running.
REQ-015 If cfg_n_to>0, SHALL loop: read RIS; if PRDATA[0]=1, write ICR=32'h1 and increment to_count; else re-read RIS.
REQ-016 When to_count equals cfg_n_to, SHALL write CTRL=0, then pulse done.
REQ-017 to_count SHALL clear on accepted start and saturate at 16'hFFFF.
REQ-018 States: IDLE, WR_CTRL0, WR_PERIOD, WR_ICR, WR_CMP, WR_CTRL, RD_RIS, WR_CLR, WR_STOP, FIN.
REQ-019 abort SHALL be sampled as a sticky request; it takes effect only at a transfer boundary, never mid-transfer, and goes to WR_STOP then FIN with aborted=1.
REQ-020 abort in IDLE SHALL have no effect; abort coinciding with start SHALL be ignored for that start.
REQ-021 busy SHALL be 1 from the cycle after start accepted until FIN; done and busy SHALL never both be 1.
REQ-022 aborted and err SHALL hold until the next accepted start.

Reset
REQ-023 PRESET SHALL asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0, done=0, aborted=0, err=0, to_count=0, abort request cleared.
REQ-024 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately; no transfer resumes after release.

Configuration
REQ-025 With TCC32_SEQ_TIMEOUT_EN defined, SHALL count ACCESS cycles; if PREADY is still 0 after 256 ACCESS cycles, SHALL end the transfer, set err=1, skip remaining transfers, go to FIN.
REQ-026 Without TCC32_SEQ_TIMEOUT_EN, SHALL wait indefinitely for PREADY and err SHALL be tied 0.

Verification
REQ-027 cfg_period=1024, cfg_cmp=512, cfg_ctrl=enable|PWM|up, n_to=0, PREADY=1 -> five writes in REQ-011 order, each 2 cycles, done 1 cycle after fifth.
REQ-028 period=20, n_to=3, PREADY=1, model RIS[0] set 20 cycles after each clear -> three ICR=1 writes, to_count=3, CTRL=0 write, done.
REQ-029 PREADY held 0 for 5 ACCESS cycles on WR_PERIOD -> signals stable, no advance until PREADY=1.
REQ-030 abort pulsed during RD_RIS ACCESS with n_to=10 -> read completes, CTRL=0 written, done with aborted=1, to_count<10.
REQ-031 With TCC32_SEQ_TIMEOUT_EN, PREADY stuck 0 on WR_ICR -> after 256 ACCESS cycles err=1, done pulses, no CMP write.
REQ-032 PRESET asserted during WR_CMP ACCESS -> PSEL=0 same cycle, IDLE, all outputs zero; start re-accepted after release.
